// File: rtl/peripheral_mpi_ahb_initiator.sv
// rtl/peripheral_mpi_ahb_initiator.sv - command/response stream to AHB-Lite SINGLE-transfer initiator
module peripheral_mpi_ahb_initiator #(
    parameter int         RSP_DEPTH = 4,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        rsp_write,
    output logic        tl_hsel_o,
    output logic [31:0] tl_haddr_o,
    output logic [31:0] tl_hwdata_o,
    output logic        tl_hwrite_o,
    output logic [2:0]  tl_hsize_o,
    output logic [2:0]  tl_hburst_o,
    output logic [3:0]  tl_hprot_o,
    output logic [1:0]  tl_htrans_o,
    output logic        tl_hmastlock_o,
    input  logic [31:0] tl_hrdata_i,
    input  logic        tl_hready_i,
    input  logic        tl_hresp_i,
    output logic        busy
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic          ap_valid_q, ap_write_q;
    logic [31:0]   ap_addr_q, ap_wdata_q;
    logic          dp_valid_q, dp_write_q;
    logic [31:0]   dp_wdata_q;
    logic [33:0]   fifo_q [RSP_DEPTH];
    logic [33:0]   rd_entry;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d, cred_q, cred_d;
    logic          err_first, advance, accept, push, pop;
    logic          addr_lsb_unused;

    // The slave ignores byte lanes; the low address bits are never forwarded.
    assign addr_lsb_unused = ^cmd_addr[1:0];

    // First ERROR cycle stalls the pipe and must not let AP be sampled.
    assign err_first = dp_valid_q & tl_hresp_i & ~tl_hready_i;
    assign advance   = tl_hready_i & ~err_first;
    assign cmd_ready = rst & (cred_q != '0) & (~ap_valid_q | advance);
    assign accept    = cmd_valid & cmd_ready;
    assign push      = advance & dp_valid_q;
    assign rsp_valid = rst & (cnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;

    assign tl_htrans_o    = (ap_valid_q & ~err_first) ? 2'b10 : 2'b00;
    assign tl_hsel_o      = ap_valid_q & ~err_first;
    assign tl_haddr_o     = ap_addr_q;
    assign tl_hwrite_o    = ap_write_q;
    assign tl_hwdata_o    = dp_wdata_q;
    assign tl_hsize_o     = 3'b010;
    assign tl_hburst_o    = 3'b000;
    assign tl_hprot_o     = HPROT_VAL;
    assign tl_hmastlock_o = 1'b0;
    assign busy           = ap_valid_q | dp_valid_q;

    assign rd_entry  = fifo_q[rd_ptr_q];
    assign rsp_rdata = rsp_valid ? rd_entry[33:2] : 32'h0;
    assign rsp_error = rsp_valid & rd_entry[1];
    assign rsp_write = rsp_valid & rd_entry[0];

    // Credits bound in-flight plus queued responses to the FIFO depth.
    always_comb begin
        cred_d = cred_q;
        if (accept && !pop) begin
            cred_d = cred_q - 1'b1;
        end else if (pop && !accept) begin
            cred_d = cred_q + 1'b1;
        end
    end

    // Response FIFO occupancy.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Address/data phase pipeline, FIFO pointers and counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ap_valid_q <= 1'b0;
            ap_write_q <= 1'b0;
            ap_addr_q  <= 32'h0;
            ap_wdata_q <= 32'h0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_wdata_q <= 32'h0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            cred_q     <= CW'(RSP_DEPTH);
        end else begin
            if (accept) begin
                ap_valid_q <= 1'b1;
                ap_write_q <= cmd_write;
                ap_addr_q  <= {cmd_addr[31:2], 2'b00};
                ap_wdata_q <= cmd_wdata;
            end else if (advance) begin
                ap_valid_q <= 1'b0;
            end
            if (advance) begin
                dp_valid_q <= ap_valid_q;
                dp_write_q <= ap_write_q;
                dp_wdata_q <= ap_wdata_q;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q  <= cnt_d;
            cred_q <= cred_d;
        end
    end

    // Completed data phase lands in the FIFO; write responses carry zero data.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {(dp_write_q ? 32'h0 : tl_hrdata_i), tl_hresp_i, dp_write_q};
        end
    end
endmodule

// File: tb/tb_peripheral_mpi_ahb_initiator.sv
// tb/tb_peripheral_mpi_ahb_initiator.sv - self-checking bench for peripheral_mpi_ahb_initiator
module tb_peripheral_mpi_ahb_initiator;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_error, rsp_write;
    logic [31:0] rsp_rdata;
    logic        tl_hsel_o, tl_hwrite_o, tl_hmastlock_o, busy;
    logic [31:0] tl_haddr_o, tl_hwdata_o, tl_hrdata_i;
    logic [2:0]  tl_hsize_o, tl_hburst_o;
    logic [3:0]  tl_hprot_o;
    logic [1:0]  tl_htrans_o;
    logic        tl_hready_i, tl_hresp_i;

    always #5 clk = ~clk;

    peripheral_mpi_ahb_initiator #(.RSP_DEPTH(4), .HPROT_VAL(4'b0011)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_write(rsp_write),
        .tl_hsel_o(tl_hsel_o), .tl_haddr_o(tl_haddr_o), .tl_hwdata_o(tl_hwdata_o),
        .tl_hwrite_o(tl_hwrite_o), .tl_hsize_o(tl_hsize_o), .tl_hburst_o(tl_hburst_o),
        .tl_hprot_o(tl_hprot_o), .tl_htrans_o(tl_htrans_o), .tl_hmastlock_o(tl_hmastlock_o),
        .tl_hrdata_i(tl_hrdata_i), .tl_hready_i(tl_hready_i), .tl_hresp_i(tl_hresp_i),
        .busy(busy)
    );

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_error;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          error;
        bit          write;
    } rsp_t;

    int checks = 0;
    int errors = 0;
    int wait_cfg = 0;
    logic [31:0] smem [16];
    logic [31:0] mmem [16];
    rsp_t        exp_q [$];
    vec_t        vecs [10];

    bit          s_valid, s_write, s_err, s_err_sent;
    logic [31:0] s_addr;
    int          s_waits;

    function automatic bit err_region(input logic [31:0] a);
        return a[31:28] == 4'hE;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d);
        int n;
        bit done;
        n = 0;
        done = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!done && n < 100) begin
            @(negedge clk);
            if (cmd_ready) done = 1;
            step();
            n++;
        end
        cmd_valid = 1'b0;
        chk("issue_accept", 32'(done), 32'd1);
    endtask

    task automatic get_rsp(output logic [31:0] rd, output logic e, output logic w);
        int n;
        bit done;
        n = 0;
        done = 0;
        rd = 32'hX;
        e = 1'bx;
        w = 1'bx;
        rsp_ready = 1'b1;
        while (!done && n < 100) begin
            @(negedge clk);
            if (rsp_valid) begin
                done = 1;
                rd = rsp_rdata;
                e = rsp_error;
                w = rsp_write;
            end
            step();
            n++;
        end
        chk("rsp_arrive", 32'(done), 32'd1);
    endtask

    // AHB-Lite slave: wait states per wait_cfg (-1 = random 0..2), ERROR for 0xE region.
    initial begin
        tl_hready_i = 1'b1;
        tl_hresp_i  = 1'b0;
        tl_hrdata_i = 32'h0;
        s_valid = 0;
        s_write = 0;
        s_err = 0;
        s_err_sent = 0;
        s_addr = 32'h0;
        s_waits = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                s_valid = 0;
            end else if (tl_hready_i) begin
                if (s_valid && s_write && !s_err) smem[s_addr[5:2]] = tl_hwdata_o;
                s_valid = (tl_htrans_o == 2'b10) && tl_hsel_o;
                s_addr = tl_haddr_o;
                s_write = tl_hwrite_o;
                s_err = err_region(tl_haddr_o);
                s_err_sent = 0;
                s_waits = (wait_cfg < 0) ? int'($urandom_range(0, 2)) : wait_cfg;
                if (s_valid) chk("haddr_align", {30'h0, tl_haddr_o[1:0]}, 32'h0);
            end
            @(posedge clk);
            #1;
            if (!s_valid) begin
                tl_hready_i = 1'b1;
                tl_hresp_i  = 1'b0;
                tl_hrdata_i = $urandom;
            end else if (s_waits > 0) begin
                tl_hready_i = 1'b0;
                tl_hresp_i  = 1'b0;
                tl_hrdata_i = $urandom;
                s_waits--;
            end else if (s_err) begin
                tl_hrdata_i = 32'h0;
                tl_hresp_i  = 1'b1;
                tl_hready_i = s_err_sent;
                s_err_sent  = 1;
            end else begin
                tl_hready_i = 1'b1;
                tl_hresp_i  = 1'b0;
                tl_hrdata_i = s_write ? $urandom : smem[s_addr[5:2]];
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic        e, w;
        int          acc, pops;

        vecs[0] = '{1'b1, 32'h0000_0020, 32'h1111_2222, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         32'h1111_2222, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 32'h0, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0024, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[4] = '{1'b1, 32'hE000_0020, 32'h0000_0BAD, 32'h0, 1'b1};
        vecs[5] = '{1'b0, 32'h0000_0020, 32'h0,         32'h1111_2222, 1'b0};
        vecs[6] = '{1'b0, 32'hE000_0004, 32'h0,         32'h0, 1'b1};
        vecs[7] = '{1'b1, 32'h0000_003F, 32'h0000_5A5A, 32'h0, 1'b0};
        vecs[8] = '{1'b0, 32'h0000_003C, 32'h0,         32'h0000_5A5A, 1'b0};
        vecs[9] = '{1'b0, 32'h0000_0023, 32'h0,         32'h1111_2222, 1'b0};

        for (int i = 0; i < 16; i++) smem[i] = 32'h0;
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = 32'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        // Reset values
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_htrans", 32'(tl_htrans_o), 32'd0);
        chk("rst_hsel", 32'(tl_hsel_o), 32'd0);
        chk("rst_haddr", tl_haddr_o, 32'h0);
        chk("rst_hwdata", tl_hwdata_o, 32'h0);
        chk("rst_hwrite", 32'(tl_hwrite_o), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        chk("rst_rsp_write", 32'(rsp_write), 32'd0);
        chk("const_hsize", 32'(tl_hsize_o), 32'd2);
        chk("const_hburst", 32'(tl_hburst_o), 32'd0);
        chk("const_hprot", 32'(tl_hprot_o), 32'd3);
        chk("const_hmastlock", 32'(tl_hmastlock_o), 32'd0);
        rst = 1'b1;
        step();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write 0x0 <- DEADBEEF, zero wait states
        wait_cfg = 0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'hDEAD_BEEF;
        @(negedge clk); chk("t1_accept", 32'(cmd_ready), 32'd1);
        step(); cmd_valid = 1'b0;
        chk("t1_htrans_n1", 32'(tl_htrans_o), 32'd2);
        chk("t1_hsel_n1", 32'(tl_hsel_o), 32'd1);
        chk("t1_hwrite_n1", 32'(tl_hwrite_o), 32'd1);
        chk("t1_haddr_n1", tl_haddr_o, 32'h0);
        step();
        chk("t1_hwdata_n2", tl_hwdata_o, 32'hDEAD_BEEF);
        chk("t1_htrans_n2", 32'(tl_htrans_o), 32'd0);
        chk("t1_rsp_valid_n2", 32'(rsp_valid), 32'd0);
        step();
        chk("t1_rsp_valid_n3", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_rdata", rsp_rdata, 32'h0);
        chk("t1_rsp_error", 32'(rsp_error), 32'd0);
        chk("t1_rsp_write", 32'(rsp_write), 32'd1);
        step();
        chk("t1_idle_after", 32'({rsp_valid, busy}), 32'd0);

        // Read 0x4 with 2 wait states returning 0x12
        smem[1] = 32'h12;
        wait_cfg = 2;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4; cmd_wdata = 32'h0;
        @(negedge clk); chk("t2_accept", 32'(cmd_ready), 32'd1);
        step(); cmd_valid = 1'b0;
        chk("t2_htrans_n1", 32'(tl_htrans_o), 32'd2);
        chk("t2_haddr_n1", tl_haddr_o, 32'h4);
        for (int c = 2; c <= 3; c++) begin
            step();
            chk("t2_wait_busy", 32'(busy), 32'd1);
            chk("t2_wait_htrans", 32'(tl_htrans_o), 32'd0);
            chk("t2_wait_haddr", tl_haddr_o, 32'h4);
            chk("t2_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        step();
        chk("t2_rsp_valid_n4", 32'(rsp_valid), 32'd0);
        step();
        chk("t2_rsp_valid_n5", 32'(rsp_valid), 32'd1);
        chk("t2_rsp_rdata", rsp_rdata, 32'h12);
        chk("t2_rsp_write", 32'(rsp_write), 32'd0);
        wait_cfg = 0;
        step();

        // Back-to-back write 0x0 <- 1 then read 0x4 returning 0x55
        smem[1] = 32'h55;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h1;
        @(negedge clk); chk("t3_accept_w", 32'(cmd_ready), 32'd1);
        step();
        cmd_write = 1'b0; cmd_addr = 32'h4; cmd_wdata = 32'h0;
        chk("t3_haddr_w", tl_haddr_o, 32'h0);
        chk("t3_hwrite_w", 32'(tl_hwrite_o), 32'd1);
        @(negedge clk); chk("t3_accept_r", 32'(cmd_ready), 32'd1);
        step(); cmd_valid = 1'b0;
        chk("t3_htrans_r", 32'(tl_htrans_o), 32'd2);
        chk("t3_haddr_r", tl_haddr_o, 32'h4);
        chk("t3_hwrite_r", 32'(tl_hwrite_o), 32'd0);
        chk("t3_hwdata_overlap", tl_hwdata_o, 32'h1);
        step();
        chk("t3_rsp1", 32'({rsp_valid, rsp_write, rsp_error}), 32'b110);
        step();
        chk("t3_rsp2", 32'({rsp_valid, rsp_write, rsp_error}), 32'b100);
        chk("t3_rsp2_rdata", rsp_rdata, 32'h55);
        step();

        // ERROR on a write with a read waiting in AP
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hE000_0000; cmd_wdata = 32'hBAD;
        @(negedge clk); chk("t4_accept_w", 32'(cmd_ready), 32'd1);
        step();
        cmd_write = 1'b0; cmd_addr = 32'h4;
        chk("t4_haddr_w", tl_haddr_o, 32'hE000_0000);
        @(negedge clk); chk("t4_accept_r", 32'(cmd_ready), 32'd1);
        step(); cmd_valid = 1'b0;
        chk("t4_err1_htrans", 32'(tl_htrans_o), 32'd0);
        chk("t4_err1_hsel", 32'(tl_hsel_o), 32'd0);
        chk("t4_err1_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("t4_err1_busy", 32'(busy), 32'd1);
        step();
        chk("t4_reissue_htrans", 32'(tl_htrans_o), 32'd2);
        chk("t4_reissue_haddr", tl_haddr_o, 32'h4);
        chk("t4_err2_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("t4_rsp_w", 32'({rsp_valid, rsp_write, rsp_error}), 32'b111);
        step();
        chk("t4_rsp_r", 32'({rsp_valid, rsp_write, rsp_error}), 32'b100);
        chk("t4_rsp_r_rdata", rsp_rdata, 32'h55);
        step();

        // Credit limit: 5 commands with responses held
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            cmd_valid = (acc < 5); cmd_write = 1'b1;
            cmd_addr = 32'h40 + 32'(acc) * 4; cmd_wdata = 32'(acc);
            @(negedge clk);
            if (cmd_valid && cmd_ready) acc++;
            step();
        end
        chk("t5_accepts_full", 32'(acc), 32'd4);
        chk("t5_cmd_ready_full", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk); chk("t5_pop_valid", 32'(rsp_valid), 32'd1);
        step();
        rsp_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cmd_valid = 1'b1;
            @(negedge clk);
            if (cmd_ready) acc++;
            step();
        end
        cmd_valid = 1'b0;
        chk("t5_one_more_accept", 32'(acc), 32'd5);
        rsp_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) pops++;
            step();
        end
        chk("t5_drain_count", 32'(pops), 32'd4);

        // Reset during a data phase with 2 responses queued
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8 + 32'(k) * 4; cmd_wdata = 32'hA0 + 32'(k);
            @(negedge clk); chk("t6_accept", 32'(cmd_ready), 32'd1);
            step();
        end
        cmd_valid = 1'b0;
        step();
        chk("t6_busy_before", 32'(busy), 32'd1);
        chk("t6_queued", 32'(rsp_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_cmd_ready_in_rst", 32'(cmd_ready), 32'd0);
        step();
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_htrans", 32'(tl_htrans_o), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_hwdata", tl_hwdata_o, 32'h0);
        rst = 1'b1;
        step();
        issue(1'b1, 32'h8, 32'h77);
        get_rsp(rd, e, w);
        chk("t6_new_rsp", 32'({e, w}), 32'b01);
        chk("t6_new_rdata", rd, 32'h0);
        step();
        chk("t6_no_stale", 32'(rsp_valid), 32'd0);

        // Table of single transfers, one wait state each
        wait_cfg = 1;
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].write, vecs[i].addr, vecs[i].wdata);
            get_rsp(rd, e, w);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_error", i), 32'(e), 32'(vecs[i].exp_error));
            chk($sformatf("vec%0d_write", i), 32'(w), 32'(vecs[i].write));
        end

        // Randomized traffic against a sequential memory model
        wait_cfg = -1;
        for (int i = 0; i < 16; i++) mmem[i] = smem[i];
        exp_q.delete();
        fork
            begin
                int n;
                bit done;
                logic [31:0] a;
                rsp_t r;
                for (int k = 0; k < 200; k++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    a = $urandom & 32'h0000_003F;
                    if ($urandom_range(0, 7) == 0) a[31:28] = 4'hE;
                    cmd_valid = 1'b1;
                    cmd_write = 1'($urandom_range(0, 1));
                    cmd_addr = a;
                    cmd_wdata = $urandom;
                    n = 0;
                    done = 0;
                    while (!done && n < 200) begin
                        @(negedge clk);
                        if (cmd_ready) begin
                            done = 1;
                            r.write = cmd_write;
                            r.error = err_region(a);
                            r.rdata = 32'h0;
                            if (!r.error && cmd_write) mmem[a[5:2]] = cmd_wdata;
                            if (!r.error && !cmd_write) r.rdata = mmem[a[5:2]];
                            exp_q.push_back(r);
                        end
                        step();
                        n++;
                    end
                    cmd_valid = 1'b0;
                    if (!done) chk("rand_accept", 32'd0, 32'd1);
                end
            end
            begin
                int got, cyc;
                bit hold;
                logic [31:0] hold_rdata;
                rsp_t r;
                got = 0;
                cyc = 0;
                hold = 0;
                hold_rdata = 32'h0;
                while (got < 200 && cyc < 20000) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (hold) begin
                        chk("rand_hold_valid", 32'(rsp_valid), 32'd1);
                        chk("rand_hold_rdata", rsp_rdata, hold_rdata);
                    end
                    hold = rsp_valid && !rsp_ready;
                    hold_rdata = rsp_rdata;
                    if (rsp_valid && rsp_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("rand_unexpected", 32'd1, 32'd0);
                        end else begin
                            r = exp_q.pop_front();
                            chk("rand_rdata", rsp_rdata, r.rdata);
                            chk("rand_error", 32'(rsp_error), 32'(r.error));
                            chk("rand_write", 32'(rsp_write), 32'(r.write));
                        end
                        got++;
                    end
                    step();
                    cyc++;
                end
                chk("rand_count", 32'(got), 32'd200);
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/peripheral_mpi_ahb_initiator.md
# peripheral_mpi_ahb_initiator

AHB-Lite bus initiator that drives the Peripheral-MPI AHB-Lite slave (`tl_h*` port set) from a simple command/response stream. Single-word reads and writes (mailbox data pushes, status polls, packet pops) are accepted on a valid/ready command channel. Each one is issued as a pipelined AHB-Lite SINGLE transfer, and its read data or error status is returned on a buffered response channel. The block sits between a processing element's control logic (or the verification sequencer) and the MPI endpoint's bus port.

## Interface
- `RSP_DEPTH`, 4: response FIFO entries; also the maximum number of in-flight plus unconsumed transfers. Power of 2, ≥2.
- `HPROT_VAL`, 4'b0011: constant driven on `tl_hprot_o`.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when valid & ready.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  byte address; bits [1:0] ignored and driven 0.
- `cmd_wdata`  in  32  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when valid & ready.
- `rsp_rdata`  out  32  read data; 0 for writes.
- `rsp_error`  out  1  transfer ended with an ERROR response.
- `rsp_write`  out  1  echo of `cmd_write`.
- `tl_hsel_o`  out  1  slave select; equals (htrans == NONSEQ).
- `tl_haddr_o`  out  32  address phase address.
- `tl_hwdata_o`  out  32  data phase write data.
- `tl_hwrite_o`  out  1  address phase direction.
- `tl_hsize_o`  out  3  constant 3'b010 (word).
- `tl_hburst_o`  out  3  constant 3'b000 (SINGLE).
- `tl_hprot_o`  out  4  `HPROT_VAL`.
- `tl_htrans_o`  out  2  IDLE 2'b00 or NONSEQ 2'b10 only.
- `tl_hmastlock_o`  out  1  constant 0.
- `tl_hrdata_i`  in  32  read data.
- `tl_hready_i`  in  1  transfer done/phase advance.
- `tl_hresp_i`  in  1  0 = OKAY, 1 = ERROR.
- `busy`  out  1  any transfer in address or data phase.

## Operation
- Two pipeline registers:
  - Address phase (AP): valid, write, addr, wdata.
  - Data phase (DP): valid, write, wdata.
- Response FIFO: `RSP_DEPTH` entries of {rdata, error, write}.
- Credit counter `cred`, width clog2(RSP_DEPTH)+1:
  - Reset value `RSP_DEPTH`.
  - −1 on command accept.
  - +1 on response pop.
  - Both in the same cycle leave it unchanged.
- `cmd_ready` = rst & (cred != 0) & (!AP.valid | advance).
  - `advance` = `tl_hready_i` & !(error first cycle).
- On accept, AP loads the command.
- On `advance`:
  - DP ← AP. AP is cleared unless a new command is accepted in the same cycle.
  - If DP was valid, its completion pushes {write ? 0 : `tl_hrdata_i`, `tl_hresp_i`, write} into the FIFO.
- Bus outputs come from AP:
  - `tl_htrans_o` = AP.valid ? NONSEQ : IDLE.
  - `tl_haddr_o`/`tl_hwrite_o` = AP fields; held when AP is invalid.
  - `tl_hwdata_o` = DP.wdata.
- Wait states (`tl_hready_i` = 0, `tl_hresp_i` = 0): AP, DP and all bus outputs are held stable.
- ERROR, first cycle (DP.valid, `tl_hresp_i` = 1, `tl_hready_i` = 0):
  - `tl_htrans_o` is forced IDLE and `tl_hsel_o` 0 for that cycle.
  - AP contents are retained and re-presented as NONSEQ starting the next cycle.
- ERROR, second cycle (`tl_hresp_i` = 1, `tl_hready_i` = 1): the DP transfer completes with `rsp_error` = 1.
- No abort on error: subsequent commands still execute, in order.
- Responses are returned strictly in command order. FIFO overflow cannot occur because of the credit scheme.

## Timing
- Reset values, while `rst` = 0 and in the cycle after it is sampled low:
  - `cmd_ready` 0, `rsp_valid` 0, `busy` 0.
  - `tl_htrans_o` IDLE, `tl_hsel_o` 0, `tl_haddr_o` 0, `tl_hwdata_o` 0, `tl_hwrite_o` 0.
  - `rsp_rdata` 0, `rsp_error` 0, `rsp_write` 0.
  - `cred` = `RSP_DEPTH`.
  - Constants are driven as listed.
- Reset mid-transfer discards AP, DP and FIFO contents; no response is produced for them.
- Latency with zero wait states:
  - Command accepted in cycle N → NONSEQ in cycle N+1.
  - Data phase in cycle N+2.
  - `rsp_valid` in cycle N+3.
  - Each slave wait state adds one cycle.
- Throughput: one transfer per cycle while `cred` > 0 and `tl_hready_i` = 1.
- Address-phase signals change only on `advance` or a new accept into an empty AP.
- `rsp_*` stay stable while `rsp_valid` & !`rsp_ready`.
- FIFO is full when `cred` = 0 and no transfer is in flight; `cmd_ready` stays low until a pop occurs.

## Test plan
- Write 0x0000_0000 ← 0xDEAD_BEEF, zero wait states:
  - `tl_htrans_o` NONSEQ in cycle N+1, `tl_hwdata_o` 0xDEAD_BEEF in cycle N+2.
  - Response {rdata 0, error 0, write 1} in cycle N+3.
- Read 0x0000_0004, slave inserts 2 wait states and returns 0x0000_0012:
  - AP/DP signals stable for 2 cycles; `rsp_rdata` 0x0000_0012 in cycle N+5.
- Back-to-back write 0x0 ← 0x1, then read 0x4 (returns 0x55):
  - Read address phase overlaps the write data phase.
  - Responses in order: write, then read with 0x55.
- Slave ERROR on a write while a read to 0x4 waits in AP:
  - During the first error cycle, `tl_htrans_o` is IDLE.
  - The read is reissued as NONSEQ in the next cycle.
  - Responses: write with error 1, then read with error 0.
- Hold `rsp_ready` = 0 and issue 5 commands with `RSP_DEPTH` = 4:
  - `cmd_ready` drops after the 4th accept.
  - One pop re-enables exactly one accept.
- Assert `rst` = 0 during a data phase with 2 responses queued:
  - Next cycle: `rsp_valid` 0, `tl_htrans_o` IDLE, `busy` 0.
  - After release, a new write completes normally.
